completed_prediction_writer: RTL and testbench
==============================================

COMPLETED_PREDICTION_WRITER -- requirements
Module: completed_prediction_writer

Interface
REQ-001 SHALL have port: clock  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: resetn  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: Start_I  input  1  one-cycle pulse that begins a transfer.
REQ-004 SHALL have port: Base_Address_I  input  10  first word address, sampled on accepted Start_I.
REQ-005 SHALL have port: Word_Count_I  input  10  number of 16-bit words to write, sampled on accepted Start_I; 0 means 1024.
REQ-006 SHALL have port: Mode_I  input  2  prediction mode, sampled on accepted Start_I: 00 forward, 01 backward, 10 bidirectional average, 11 reserved (treated as 00).
REQ-007 SHALL have port: Pixel_Valid_I  input  1  forward and backward samples are present.
REQ-008 SHALL have port: Forward_Pixel_I  input  8  forward prediction sample.
REQ-009 SHALL have port: Backward_Pixel_I  input  8  backward prediction sample.
REQ-010 SHALL have port: Pixel_Ready_O  output  1  block accepts a sample this cycle.
REQ-011 SHALL have port: Write_En_O  output  1  buffer word write strobe.
REQ-012 SHALL have port: Address_O  output  10  buffer word address.
REQ-013 SHALL have port: Data_O  output  16  buffer word data: [7:0] even byte, [15:8] odd byte.
REQ-014 SHALL have port: Busy_O  output  1  transfer in progress.
REQ-015 SHALL have port: Done_O  output  1  one-cycle pulse after last word write.

Function
REQ-016 SHALL implement FSM states IDLE, LOW, HIGH, FLUSH.
REQ-017 SHALL, in IDLE, accept Start_I, load address/count/mode registers, and go to LOW next cycle; Start_I in any other state SHALL be ignored.
REQ-018 SHALL assert Pixel_Ready_O combinationally only in LOW and HIGH; a sample is accepted when Pixel_Valid_I and Pixel_Ready_O are both 1.
REQ-019 SHALL compute the selected pixel as forward (mode 00/11), backward (01), or (F+B+1)>>1 with 9-bit intermediate (10); 255 and 255 averaged SHALL give 255.
REQ-020 SHALL, on accepted sample in LOW, store it as low byte and go to HIGH.
REQ-021 SHALL, on accepted sample in HIGH, register Write_En_O=1, Address_O=current address, Data_O={sample, low byte} for exactly the next cycle, then increment address (mod 1024) and decrement count.
REQ-022 SHALL, after the write of the final word, go to FLUSH, and from FLUSH return to IDLE with Done_O=1 for one cycle; otherwise return to LOW.
REQ-023 SHALL hold state and registers unchanged in LOW/HIGH while Pixel_Valid_I=0 (arbitrary stalls allowed).
REQ-024 SHALL wrap Address_O from 1023 to 0 without error.
REQ-025 SHALL drive Busy_O=1 in LOW, HIGH, FLUSH and 0 in IDLE.
REQ-026 SHALL keep Write_En_O=0 in all cycles other than those of REQ-021; at most one write per two accepted samples.
REQ-027 SHALL sustain one sample per cycle with no bubbles (throughput 1 word per 2 cycles).

Reset
REQ-028 SHALL, on resetn=0, immediately force IDLE, Write_En_O=0, Done_O=0, Busy_O=0, Address_O=0, Data_O=0, Pixel_Ready_O=0, and clear count/mode/low-byte registers.
REQ-029 SHALL, on reset mid-transfer, discard any partial word, issue no further writes, and require a new Start_I.

Verification
REQ-030 Bench SHALL cover: Start base=0x010, count=2, mode 00, samples F=01,02,03,04 continuous -> writes (0x010,0x0201),(0x011,0x0403), Done_O one cycle after second write.
REQ-031 Bench SHALL cover: mode 10, F=0x10,B=0x13 and F=0xFF,B=0xFF, count=1 -> single write Data_O=0xFF12.
REQ-032 Bench SHALL cover: base=0x3FF, count=2, mode 01 -> writes at 0x3FF then 0x000 with backward samples.
REQ-033 Bench SHALL cover: random Pixel_Valid_I gaps and Start_I pulses during Busy_O -> identical write sequence to gapless run; extra Start_I ignored.
REQ-034 Bench SHALL cover: resetn low after 3 samples of count=4 transfer -> all outputs at reset values, no write for partial word, subsequent Start_I operates normally.

Source files
------------

// File: rtl/completed_prediction_writer.sv
`default_nettype none
// ============================================================================
// Module   : completed_prediction_writer
// Purpose  : Collects forward/backward prediction samples, selects (or
//            averages) them per the transfer mode, packs two consecutive
//            8-bit results into one 16-bit word and writes the words to a
//            1024-entry buffer starting at a base address.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock            in   1   sole clock, rising edge
//   resetn           in   1   asynchronous active-low reset
//   Start_I          in   1   transfer start pulse (honoured only when idle)
//   Base_Address_I   in  10   first word address
//   Word_Count_I     in  10   words to write, 0 encodes 1024
//   Mode_I           in   2   00 fwd, 01 bwd, 10 average, 11 treated as fwd
//   Pixel_Valid_I    in   1   forward/backward samples present
//   Forward_Pixel_I  in   8   forward prediction sample
//   Backward_Pixel_I in   8   backward prediction sample
//   Pixel_Ready_O    out  1   sample accepted this cycle when valid
//   Write_En_O       out  1   buffer write strobe
//   Address_O        out 10   buffer word address
//   Data_O           out 16   {odd byte, even byte}
//   Busy_O           out  1   transfer in progress
//   Done_O           out  1   one-cycle pulse after final word write
// ============================================================================
module completed_prediction_writer (
  input  logic        clock,
  input  logic        resetn,
  input  logic        Start_I,
  input  logic [9:0]  Base_Address_I,
  input  logic [9:0]  Word_Count_I,
  input  logic [1:0]  Mode_I,
  input  logic        Pixel_Valid_I,
  input  logic [7:0]  Forward_Pixel_I,
  input  logic [7:0]  Backward_Pixel_I,
  output logic        Pixel_Ready_O,
  output logic        Write_En_O,
  output logic [9:0]  Address_O,
  output logic [15:0] Data_O,
  output logic        Busy_O,
  output logic        Done_O
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOW   = 2'd1,
    HIGH  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [1:0] C_MODE_FWD = 2'b00;
  localparam logic [1:0] C_MODE_BWD = 2'b01;
  localparam logic [1:0] C_MODE_AVG = 2'b10;

  state_t      state_q, state_d;
  logic [9:0]  addr_q,  addr_d;
  logic [9:0]  count_q, count_d;
  logic [1:0]  mode_q,  mode_d;
  logic [7:0]  low_q,   low_d;
  logic        we_q,    we_d;
  logic [9:0]  waddr_q, waddr_d;
  logic [15:0] data_q,  data_d;
  logic        done_q,  done_d;

  logic        ready_w;
  logic        accept_w;
  logic [8:0]  avg_sum_w;
  logic [7:0]  pixel_w;

  assign ready_w  = (state_q == LOW) || (state_q == HIGH);
  assign accept_w = ready_w && Pixel_Valid_I;

  // 9-bit sum so 255+255+1 does not overflow; dropping bit 0 is the >>1.
  assign avg_sum_w = {1'b0, Forward_Pixel_I} + {1'b0, Backward_Pixel_I} + 9'd1;

  always_comb begin
    case (mode_q)
      C_MODE_BWD: pixel_w = Backward_Pixel_I;
      C_MODE_AVG: pixel_w = avg_sum_w[8:1];
      default:    pixel_w = Forward_Pixel_I;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    mode_d  = mode_q;
    low_d   = low_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start_I) begin
          addr_d  = Base_Address_I;
          count_d = Word_Count_I;
          // Reserved mode folds onto forward at load time so the datapath
          // only ever sees three encodings.
          mode_d  = (Mode_I == 2'b11) ? C_MODE_FWD : Mode_I;
          state_d = LOW;
        end
      end
      LOW: begin
        if (accept_w) begin
          low_d   = pixel_w;
          state_d = HIGH;
        end
      end
      HIGH: begin
        if (accept_w) begin
          we_d    = 1'b1;
          waddr_d = addr_q;
          data_d  = {pixel_w, low_q};
          addr_d  = addr_q + 10'd1;
          // Count of 0 means 1024: decrementing 0 yields 1023 and the
          // transfer still ends when the count reaches 1.
          count_d = count_q - 10'd1;
          state_d = (count_q == 10'd1) ? FLUSH : LOW;
        end
      end
      FLUSH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= 10'd0;
      count_q <= 10'd0;
      mode_q  <= 2'd0;
      low_q   <= 8'd0;
      we_q    <= 1'b0;
      waddr_q <= 10'd0;
      data_q  <= 16'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      mode_q  <= mode_d;
      low_q   <= low_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign Pixel_Ready_O = ready_w;
  assign Write_En_O    = we_q;
  assign Address_O     = waddr_q;
  assign Data_O        = data_q;
  assign Busy_O        = (state_q != IDLE);
  assign Done_O        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_completed_prediction_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_completed_prediction_writer
// Purpose  : Directed scoreboard bench for completed_prediction_writer.
//            Stimulus pushes expected {address, data} words; a monitor on the
//            falling edge pops and compares on every write strobe and checks
//            Done_O framing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_completed_prediction_writer;

  logic        clock;
  logic        resetn;
  logic        Start_I;
  logic [9:0]  Base_Address_I;
  logic [9:0]  Word_Count_I;
  logic [1:0]  Mode_I;
  logic        Pixel_Valid_I;
  logic [7:0]  Forward_Pixel_I;
  logic [7:0]  Backward_Pixel_I;
  logic        Pixel_Ready_O;
  logic        Write_En_O;
  logic [9:0]  Address_O;
  logic [15:0] Data_O;
  logic        Busy_O;
  logic        Done_O;

  completed_prediction_writer u_dut (
    .clock            (clock),
    .resetn           (resetn),
    .Start_I          (Start_I),
    .Base_Address_I   (Base_Address_I),
    .Word_Count_I     (Word_Count_I),
    .Mode_I           (Mode_I),
    .Pixel_Valid_I    (Pixel_Valid_I),
    .Forward_Pixel_I  (Forward_Pixel_I),
    .Backward_Pixel_I (Backward_Pixel_I),
    .Pixel_Ready_O    (Pixel_Ready_O),
    .Write_En_O       (Write_En_O),
    .Address_O        (Address_O),
    .Data_O           (Data_O),
    .Busy_O           (Busy_O),
    .Done_O           (Done_O)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          start_cyc = 0;
  int          done_cyc  = 0;
  int          done_seen = 0;
  logic        prev_we   = 1'b0;
  logic        prev_done = 1'b0;
  logic [25:0] exp_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc = cyc + 1;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: every write strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    logic [25:0] e;
    if (Write_En_O) begin
      if (exp_q.size() == 0) begin
        n_tests = n_tests + 1;
        n_fail  = n_fail + 1;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                 Address_O, Data_O);
      end else begin
        e = exp_q.pop_front();
        check("write_word", {6'd0, Address_O, Data_O}, {6'd0, e});
      end
    end
    if (Done_O) begin
      check("done_after_write", {31'd0, prev_we}, 32'd1);
      check("done_single_pulse", {31'd0, prev_done}, 32'd0);
      done_cyc  = cyc;
      done_seen = done_seen + 1;
    end
    prev_we   = Write_En_O;
    prev_done = Done_O;
  end

  task automatic push_exp(input logic [9:0] a, input logic [15:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic start(input logic [9:0] base, input logic [9:0] cnt,
                       input logic [1:0] mode);
    Start_I        = 1'b1;
    Base_Address_I = base;
    Word_Count_I   = cnt;
    Mode_I         = mode;
    @(posedge clock); #1;
    start_cyc = cyc;
    Start_I   = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; returns likewise after acceptance.
  task automatic feed(input logic [7:0] f, input logic [7:0] b);
    int t;
    Pixel_Valid_I    = 1'b1;
    Forward_Pixel_I  = f;
    Backward_Pixel_I = b;
    t = 0;
    while (!Pixel_Ready_O && t < 50) begin
      @(posedge clock); #1;
      t++;
    end
    if (t >= 50) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL ready_timeout: got ready 0 expected 1");
    end
    @(posedge clock); #1;
  endtask

  task automatic idle_inputs();
    Pixel_Valid_I    = 1'b0;
    Forward_Pixel_I  = 8'h00;
    Backward_Pixel_I = 8'h00;
  endtask

  // Waits for the next Done_O; exp_delta < 0 skips the latency check.
  task automatic wait_done(input string name, input int exp_delta);
    int base;
    int t;
    base = done_seen;
    t    = 0;
    while (done_seen == base && t < 5000) begin
      @(negedge clock); #1;
      t++;
    end
    if (done_seen == base) begin
      n_tests = n_tests + 1;
      n_fail  = n_fail + 1;
      $display("FAIL %s_done_timeout: got no Done_O expected one", name);
    end else if (exp_delta >= 0) begin
      check({name, "_done_latency"}, done_cyc - start_cyc, exp_delta);
    end
    @(posedge clock); #1;
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_we"},    {31'd0, Write_En_O},    32'd0);
    check({name, "_done"},  {31'd0, Done_O},        32'd0);
    check({name, "_busy"},  {31'd0, Busy_O},        32'd0);
    check({name, "_ready"}, {31'd0, Pixel_Ready_O}, 32'd0);
    check({name, "_addr"},  {22'd0, Address_O},     32'd0);
    check({name, "_data"},  {16'd0, Data_O},        32'd0);
  endtask

  initial begin
    resetn = 1'b1;
    Start_I = 1'b0;
    Base_Address_I = '0;
    Word_Count_I = '0;
    Mode_I = '0;
    idle_inputs();
    #2 resetn = 1'b0;
    #1 check_reset_outputs("reset");
    @(posedge clock); @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Forward mode, two words, no stalls: done 5 cycles after start edge.
    push_exp(10'h010, 16'h0201);
    push_exp(10'h011, 16'h0403);
    start(10'h010, 10'd2, 2'b00);
    check("busy_after_start", {31'd0, Busy_O}, 32'd1);
    feed(8'h01, 8'hF1);
    feed(8'h02, 8'hF2);
    feed(8'h03, 8'hF3);
    feed(8'h04, 8'hF4);
    idle_inputs();
    wait_done("fwd", 5);
    check("idle_busy", {31'd0, Busy_O}, 32'd0);

    // Average mode with rounding, including the 255/255 corner.
    push_exp(10'h100, 16'hFF12);
    start(10'h100, 10'd1, 2'b10);
    feed(8'h10, 8'h13);
    feed(8'hFF, 8'hFF);
    idle_inputs();
    wait_done("avg", 3);

    // Backward mode across the 1023 -> 0 address wrap.
    push_exp(10'h3FF, 16'hA2A1);
    push_exp(10'h000, 16'hB2B1);
    start(10'h3FF, 10'd2, 2'b01);
    feed(8'h11, 8'hA1);
    feed(8'h12, 8'hA2);
    feed(8'h13, 8'hB1);
    feed(8'h14, 8'hB2);
    idle_inputs();
    wait_done("bwd_wrap", 5);

    // Reserved mode behaves as forward.
    push_exp(10'h050, 16'h4433);
    start(10'h050, 10'd1, 2'b11);
    feed(8'h33, 8'h99);
    feed(8'h44, 8'h98);
    idle_inputs();
    wait_done("mode11", 3);

    // Random valid gaps with stray Start_I pulses while busy and in FLUSH.
    push_exp(10'h020, 16'h1211);
    push_exp(10'h021, 16'h1413);
    push_exp(10'h022, 16'h1615);
    start(10'h020, 10'd3, 2'b00);
    Start_I = 1'b1; Base_Address_I = 10'h3AA; Word_Count_I = 10'd7; Mode_I = 2'b01;
    @(posedge clock); #1;
    Start_I = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int g;
      g = $urandom_range(0, 3);
      for (int k = 0; k < g; k++) begin
        Pixel_Valid_I   = 1'b0;
        Forward_Pixel_I = 8'hEE;
        Start_I         = (k == 0);
        @(posedge clock); #1;
        Start_I = 1'b0;
      end
      feed(8'(8'h11 + i), 8'h00);
    end
    idle_inputs();
    Start_I = 1'b1;
    @(posedge clock); #1;
    Start_I = 1'b0;
    wait_done("gaps", -1);
    check("gaps_idle_after", {31'd0, Busy_O}, 32'd0);

    // Count 0 means 1024 words; base 0x200 also wraps the address.
    for (int j = 0; j < 1024; j++)
      push_exp(10'(10'h200 + j), {8'(2 * j + 1), 8'(2 * j)});
    start(10'h200, 10'd0, 2'b00);
    for (int i = 0; i < 2048; i++) feed(8'(i), 8'h00);
    idle_inputs();
    wait_done("count1024", 2049);

    // Reset after three samples of a four-word transfer.
    push_exp(10'h080, 16'hA1A0);
    start(10'h080, 10'd4, 2'b00);
    feed(8'hA0, 8'h00);
    feed(8'hA1, 8'h00);
    feed(8'hA2, 8'h00);
    idle_inputs();
    resetn = 1'b0;
    #1 check_reset_outputs("midreset");
    @(posedge clock); @(posedge clock); #1;
    check("midreset_held_busy", {31'd0, Busy_O}, 32'd0);
    resetn = 1'b1;
    @(posedge clock); #1;
    check("post_reset_no_resume", {31'd0, Busy_O}, 32'd0);
    push_exp(10'h0C0, 16'h6B5A);
    start(10'h0C0, 10'd1, 2'b00);
    feed(8'h5A, 8'h00);
    feed(8'h6B, 8'h00);
    idle_inputs();
    wait_done("after_reset", 3);

    repeat (5) @(posedge clock);
    #1 check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
